// File: rtl/pattern_recorder.sv
// Records synchronized switch samples, one per tick, into pattern memory.
// Start/stop buttons are edge-detected after a two-flop synchronizer.
module pattern_recorder #(
    parameter int WIDTH  = 5,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic [WIDTH-1:0]  sw,
    input  logic              rec_start,
    input  logic              rec_stop,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   length
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  sw_s1_q, sw_s2_q;
    logic [2:0]        start_q, stop_q;
    logic              start_rise, stop_rise, capture;

    // [0],[1] synchronize; [2] is the previous synchronized level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            start_q <= '0;
            stop_q  <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            start_q <= {start_q[1:0], rec_start};
            stop_q  <= {stop_q[1:0], rec_stop};
        end
    end

    assign start_rise = start_q[1] & ~start_q[2];
    assign stop_rise  = stop_q[1] & ~stop_q[2];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        length_d  = length_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        capture   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d  = ARM;
                    ptr_d    = '0;
                    length_d = '0;
                end
            end
            ARM: begin
                ptr_d    = '0;
                length_d = '0;
                if (tick) begin
                    capture = 1'b1;
                    state_d = stop_rise ? DONE : CAPTURE;
                end else if (stop_rise) begin
                    state_d = DONE;
                end
            end
            CAPTURE: begin
                capture = tick;
                if (stop_rise) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // a write on the same tick as stop still lands before DONE
        if (capture) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_d;
            wr_data_d = sw_s2_q;
            length_d  = length_d + (ADDR_W+1)'(1);
            if (length_d == DEPTH_L) state_d = DONE;
            else ptr_d = ptr_d + ADDR_W'(1);
        end
        busy_d = (state_d == ARM) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            length_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            length_q  <= length_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign length  = length_q;

endmodule
